// File: rtl/gate_fault_checker_pkg.sv
// Shared types and golden-function helpers for the 2-input gate fault checker.
// Vector index i encodes {a,b}; results are classified by which output values were seen.
package gate_check_pkg;

   typedef enum logic [1:0] {
      OP_AND  = 2'b00,
      OP_OR   = 2'b01,
      OP_XOR  = 2'b10,
      OP_NAND = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      FAULT_NONE  = 2'b00,
      FAULT_SA0   = 2'b01,
      FAULT_SA1   = 2'b10,
      FAULT_OTHER = 2'b11
   } fault_e;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_e;

   localparam int NUM_VECTORS = 4;

   function automatic logic golden(input op_e op, input logic [1:0] idx);
      logic a;
      logic b;
      a = idx[1];
      b = idx[0];
      case (op)
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         default: return ~(a & b);
      endcase
   endfunction

   // A failing run that only ever produced 0 (or only 1) looks like a stuck output.
   function automatic fault_e classify(input logic [2:0] err, input logic saw0, input logic saw1);
      if (err == 3'd0)
         return FAULT_NONE;
      else if (!saw1)
         return FAULT_SA0;
      else if (!saw0)
         return FAULT_SA1;
      else
         return FAULT_OTHER;
   endfunction

endpackage

// File: rtl/gate_fault_checker_golden.sv
// Combinational golden model of a 2-input gate; op selects AND/OR/XOR/NAND.
import gate_check_pkg::*;

module golden_gate (
   input  logic [1:0] op,
   input  logic       a,
   input  logic       b,
   output logic       expected
);

   assign expected = golden(op_e'(op), {a, b});

endmodule

// File: rtl/gate_fault_checker.sv
// Exhaustive 2-input stimulus/response checker: drives 00..11, samples dut_out
// after SETTLE_CYCLES, and reports mismatch count, per-vector mask and stuck-at class.
import gate_check_pkg::*;

module gate_fault_checker #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [1:0] op,
   output logic       drv_a,
   output logic       drv_b,
   input  logic       dut_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count,
   output logic [3:0] fail_mask,
   output logic [1:0] fault
);

   localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   localparam logic [1:0] ST_IDLE   = S_IDLE;
   localparam logic [1:0] ST_SETTLE = S_SETTLE;
   localparam logic [1:0] ST_SAMPLE = S_SAMPLE;
   localparam logic [1:0] ST_DONE   = S_DONE;

   logic [1:0]    r_state;
   logic [1:0]    r_op;
   logic [1:0]    r_idx;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_err;
   logic [3:0]    r_mask;
   logic          r_pass;
   logic [1:0]    r_fault;
   logic          r_saw0;
   logic          r_saw1;

   logic          w_expected;
   logic          w_mismatch;
   logic          w_is0;
   logic          w_is1;
   logic [2:0]    w_err_nx;
   logic [3:0]    w_mask_nx;
   logic          w_saw0_nx;
   logic          w_saw1_nx;

   golden_gate u_golden (
      .op       (r_op),
      .a        (r_idx[1]),
      .b        (r_idx[0]),
      .expected (w_expected)
   );

   // Default to mismatch so an unknown dut_out (neither 0 nor 1) counts as a failure.
   always_comb begin
      w_mismatch = 1'b1;
      w_is0      = 1'b0;
      w_is1      = 1'b0;
      if (dut_out == 1'b1) begin
         w_is1      = 1'b1;
         w_mismatch = ~w_expected;
      end else if (dut_out == 1'b0) begin
         w_is0      = 1'b1;
         w_mismatch = w_expected;
      end
   end

   assign w_err_nx  = r_err + {2'b00, w_mismatch};
   assign w_mask_nx = r_mask | (4'(w_mismatch) << r_idx);
   assign w_saw0_nx = r_saw0 | w_is0;
   assign w_saw1_nx = r_saw1 | w_is1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_op    <= '0;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_err   <= '0;
         r_mask  <= '0;
         r_pass  <= 1'b0;
         r_fault <= FAULT_NONE;
         r_saw0  <= 1'b0;
         r_saw1  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_op    <= op;
                  r_idx   <= '0;
                  r_cnt   <= '0;
                  r_err   <= '0;
                  r_mask  <= '0;
                  r_pass  <= 1'b0;
                  r_fault <= FAULT_NONE;
                  r_saw0  <= 1'b0;
                  r_saw1  <= 1'b0;
                  r_state <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (r_cnt == CW'(SETTLE_CYCLES - 1)) begin
                  r_cnt   <= '0;
                  r_state <= ST_SAMPLE;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            ST_SAMPLE: begin
               r_err  <= w_err_nx;
               r_mask <= w_mask_nx;
               r_saw0 <= w_saw0_nx;
               r_saw1 <= w_saw1_nx;
               // Results are published on the edge entering DONE so they coincide with done.
               if (r_idx == 2'(NUM_VECTORS - 1)) begin
                  r_pass  <= (w_err_nx == 3'd0);
                  r_fault <= classify(w_err_nx, w_saw0_nx, w_saw1_nx);
                  r_state <= ST_DONE;
               end else begin
                  r_idx   <= r_idx + 2'd1;
                  r_state <= ST_SETTLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign drv_a     = r_idx[1];
   assign drv_b     = r_idx[0];
   assign busy      = (r_state != ST_IDLE);
   assign done      = (r_state == ST_DONE);
   assign pass      = r_pass;
   assign err_count = r_err;
   assign fail_mask = r_mask;
   assign fault     = r_fault;

endmodule

// File: tb/tb_gate_fault_checker.sv
// Scoreboard bench for gate_fault_checker: a truth-table DUT is checked against
// a spec-level reference model; a monitor compares results whenever done pulses.
module tb_gate_fault_checker;

   typedef struct packed {
      logic       pass;
      logic [2:0] err;
      logic [3:0] mask;
      logic [1:0] fault;
   } res_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [1:0] op = 2'b00;
   logic       drv_a;
   logic       drv_b;
   logic       dut_out;
   logic       busy;
   logic       done;
   logic       pass;
   logic [2:0] err_count;
   logic [3:0] fail_mask;
   logic [1:0] fault;
   logic [3:0] dut_tt = 4'b0000;

   int          total = 0;
   int          bad = 0;
   res_t        exp_q[$];
   int unsigned cyc = 0;
   int unsigned acc_cyc = 0;

   gate_fault_checker #(.SETTLE_CYCLES(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .op        (op),
      .drv_a     (drv_a),
      .drv_b     (drv_b),
      .dut_out   (dut_out),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .err_count (err_count),
      .fail_mask (fail_mask),
      .fault     (fault)
   );

   always #5 clk = ~clk;

   // Device under test modelled as a truth table indexed by {a,b}.
   assign dut_out = dut_tt[{drv_a, drv_b}];

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic gold(input logic [1:0] o, input logic a, input logic b);
      case (o)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return a ^ b;
         default: return ~(a & b);
      endcase
   endfunction

   function automatic res_t model(input logic [1:0] o, input logic [3:0] tt);
      res_t r;
      r = '0;
      for (int v = 0; v < 4; v++) begin
         if (tt[v] != gold(o, v >= 2, (v % 2) == 1)) begin
            r.err     = r.err + 3'd1;
            r.mask[v] = 1'b1;
         end
      end
      r.pass = (r.err == 3'd0);
      if (r.pass)            r.fault = 2'b00;
      else if (tt == 4'h0)   r.fault = 2'b01;
      else if (tt == 4'hF)   r.fault = 2'b10;
      else                   r.fault = 2'b11;
      return r;
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst_n && start && !busy)
         acc_cyc <= cyc;
   end

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      res_t e;
      if (rst_n && done) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("pass",      int'(pass),      int'(e.pass));
            chk("err_count", int'(err_count), int'(e.err));
            chk("fail_mask", int'(fail_mask), int'(e.mask));
            chk("fault",     int'(fault),     int'(e.fault));
            chk("latency",   int'(cyc - acc_cyc), 13);
         end
      end
   end

   task automatic chk_reset(input string tag);
      chk({tag, "_drv"},   int'({drv_a, drv_b}), 0);
      chk({tag, "_busy"},  int'(busy), 0);
      chk({tag, "_done"},  int'(done), 0);
      chk({tag, "_pass"},  int'(pass), 0);
      chk({tag, "_err"},   int'(err_count), 0);
      chk({tag, "_mask"},  int'(fail_mask), 0);
      chk({tag, "_fault"}, int'(fault), 0);
   endtask

   task automatic run(input logic [1:0] o, input logic [3:0] tt, input bit poke);
      res_t e;
      int   n;
      e      = model(o, tt);
      op     = o;
      dut_tt = tt;
      exp_q.push_back(e);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (busy && n < 100) begin
         n++;
         if (poke && n == 3) begin
            start = 1'b1;
            op    = ~o;
         end else begin
            start = 1'b0;
         end
         if (n == 5)
            op = 2'($urandom_range(0, 3));
         @(negedge clk);
      end
      start = 1'b0;
      chk("busy_cycles", n, 13);
      chk("hold_pass",  int'(pass),      int'(e.pass));
      chk("hold_err",   int'(err_count), int'(e.err));
      chk("hold_mask",  int'(fail_mask), int'(e.mask));
      chk("hold_fault", int'(fault),     int'(e.fault));
      chk("hold_drv",   int'({drv_a, drv_b}), 3);
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset("rst");
      rst_n = 1'b1;
      @(negedge clk);

      run(2'd0, 4'b1000, 1'b0);
      run(2'd0, 4'b0000, 1'b0);
      run(2'd0, 4'b1111, 1'b0);
      run(2'd0, 4'b0110, 1'b0);
      run(2'd0, 4'b1000, 1'b1);
      run(2'd3, 4'b0111, 1'b0);

      // Abort during vector 2 settle: no done pulse, outputs back to reset values.
      op     = 2'd2;
      dut_tt = 4'b0110;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      chk("abort_busy", int'(busy), 1);
      chk("abort_vec",  int'({drv_a, drv_b}), 2);
      #1 rst_n = 1'b0;
      #1;
      chk_reset("abort");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_abort_done", int'(done), 0);

      run(2'd2, 4'b0110, 1'b0);

      for (int i = 0; i < 20; i++)
         run(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), (i % 4) == 1);

      repeat (3) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
